// File: rtl/dp_ram_1k18.sv
// rtl/dp_ram_1k18.sv - 1024x18 true dual-port block RAM with per-port write modes
module dp_ram_1k18 #(
  parameter string       WRITE_MODE_A = "WRITE_FIRST",
  parameter string       WRITE_MODE_B = "WRITE_FIRST",
  parameter logic [17:0] INIT_A       = 18'h0,
  parameter logic [17:0] INIT_B       = 18'h0,
  parameter logic [17:0] SRVAL_A      = 18'h0,
  parameter logic [17:0] SRVAL_B      = 18'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  ADDRA,
  input  logic [15:0] DIA,
  input  logic [1:0]  DIPA,
  input  logic        ENA,
  input  logic        WEA,
  input  logic        SSRA,
  output logic [15:0] DOA,
  output logic [1:0]  DOPA,
  input  logic [9:0]  ADDRB,
  input  logic [15:0] DIB,
  input  logic [1:0]  DIPB,
  input  logic        ENB,
  input  logic        WEB,
  input  logic        SSRB,
  output logic [15:0] DOB,
  output logic [1:0]  DOPB
);

  // Write-mode encoding resolved once from the string parameters.
  localparam logic [1:0] MODE_WF = 2'd0;
  localparam logic [1:0] MODE_RF = 2'd1;
  localparam logic [1:0] MODE_NC = 2'd2;

  localparam logic [1:0] L_MODE_A = (WRITE_MODE_A == "READ_FIRST") ? MODE_RF :
                                    (WRITE_MODE_A == "NO_CHANGE")  ? MODE_NC : MODE_WF;
  localparam logic [1:0] L_MODE_B = (WRITE_MODE_B == "READ_FIRST") ? MODE_RF :
                                    (WRITE_MODE_B == "NO_CHANGE")  ? MODE_NC : MODE_WF;

  // Storage word layout: parity in [17:16], data in [15:0].
  logic [17:0] r_mem [1024];
  logic [17:0] r_qa;
  logic [17:0] r_qb;
  logic [17:0] w_wda;
  logic [17:0] w_wdb;
  logic        w_wr_a;
  logic        w_wr_b;

  assign w_wda  = {DIPA, DIA};
  assign w_wdb  = {DIPB, DIB};
  assign w_wr_a = ENA & WEA;
  assign w_wr_b = ENB & WEB;

  // Array writes; port A is applied last so it wins a same-address collision.
  // No reset here: rst_n only touches the output registers.
  always_ff @(posedge clk) begin
    if (w_wr_b) r_mem[ADDRB] <= w_wdb;
    if (w_wr_a) r_mem[ADDRA] <= w_wda;
  end

  // Port A output register: async INIT, then SSR > read > write-mode selection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_qa <= INIT_A;
    end else if (ENA) begin
      if (SSRA) begin
        r_qa <= SRVAL_A;
      end else if (!WEA) begin
        r_qa <= r_mem[ADDRA];
      end else begin
        case (L_MODE_A)
          MODE_RF: r_qa <= r_mem[ADDRA];
          MODE_NC: r_qa <= r_qa;
          default: r_qa <= w_wda;
        endcase
      end
    end
  end

  // Port B output register: same rules as port A, own parameters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_qb <= INIT_B;
    end else if (ENB) begin
      if (SSRB) begin
        r_qb <= SRVAL_B;
      end else if (!WEB) begin
        r_qb <= r_mem[ADDRB];
      end else begin
        case (L_MODE_B)
          MODE_RF: r_qb <= r_mem[ADDRB];
          MODE_NC: r_qb <= r_qb;
          default: r_qb <= w_wdb;
        endcase
      end
    end
  end

  assign {DOPA, DOA} = r_qa;
  assign {DOPB, DOB} = r_qb;

endmodule

// File: tb/tb_dp_ram_1k18.sv
// tb/tb_dp_ram_1k18.sv - three mode variants of dp_ram_1k18 checked against a word-level model
module tb_dp_ram_1k18;

  localparam logic [17:0] P_INIT_A  = 18'h3_1234;
  localparam logic [17:0] P_SRVAL_A = 18'h0_00FF;
  localparam logic [17:0] P_INIT_B  = 18'h0_0ABC;
  localparam logic [17:0] P_SRVAL_B = 18'h2_0F0F;
  localparam int WF = 0;
  localparam int RF = 1;
  localparam int NC = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  addra, addrb;
  logic [15:0] dia, dib;
  logic [1:0]  dipa, dipb;
  logic        ena, wea, ssra, enb, web, ssrb;

  logic [15:0] doa_0, doa_1, doa_2, dob_0, dob_1, dob_2;
  logic [1:0]  dopa_0, dopa_1, dopa_2, dopb_0, dopb_1, dopb_2;
  logic [17:0] qa [3];
  logic [17:0] qb [3];

  // instance 0: A READ_FIRST, B WRITE_FIRST; 1: both WRITE_FIRST; 2: both NO_CHANGE
  int mode_a [3] = '{RF, WF, NC};
  int mode_b [3] = '{WF, WF, NC};

  logic [17:0] m_mem [1024];
  logic [17:0] e_a [3];
  logic [17:0] e_b [3];

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  dp_ram_1k18 #(.WRITE_MODE_A("READ_FIRST"), .WRITE_MODE_B("WRITE_FIRST"),
                .INIT_A(P_INIT_A), .INIT_B(P_INIT_B), .SRVAL_A(P_SRVAL_A), .SRVAL_B(P_SRVAL_B))
  u_rf (.clk(clk), .rst_n(rst_n),
        .ADDRA(addra), .DIA(dia), .DIPA(dipa), .ENA(ena), .WEA(wea), .SSRA(ssra), .DOA(doa_0), .DOPA(dopa_0),
        .ADDRB(addrb), .DIB(dib), .DIPB(dipb), .ENB(enb), .WEB(web), .SSRB(ssrb), .DOB(dob_0), .DOPB(dopb_0));

  dp_ram_1k18 #(.WRITE_MODE_A("WRITE_FIRST"), .WRITE_MODE_B("WRITE_FIRST"),
                .INIT_A(P_INIT_A), .INIT_B(P_INIT_B), .SRVAL_A(P_SRVAL_A), .SRVAL_B(P_SRVAL_B))
  u_wf (.clk(clk), .rst_n(rst_n),
        .ADDRA(addra), .DIA(dia), .DIPA(dipa), .ENA(ena), .WEA(wea), .SSRA(ssra), .DOA(doa_1), .DOPA(dopa_1),
        .ADDRB(addrb), .DIB(dib), .DIPB(dipb), .ENB(enb), .WEB(web), .SSRB(ssrb), .DOB(dob_1), .DOPB(dopb_1));

  dp_ram_1k18 #(.WRITE_MODE_A("NO_CHANGE"), .WRITE_MODE_B("NO_CHANGE"),
                .INIT_A(P_INIT_A), .INIT_B(P_INIT_B), .SRVAL_A(P_SRVAL_A), .SRVAL_B(P_SRVAL_B))
  u_nc (.clk(clk), .rst_n(rst_n),
        .ADDRA(addra), .DIA(dia), .DIPA(dipa), .ENA(ena), .WEA(wea), .SSRA(ssra), .DOA(doa_2), .DOPA(dopa_2),
        .ADDRB(addrb), .DIB(dib), .DIPB(dipb), .ENB(enb), .WEB(web), .SSRB(ssrb), .DOB(dob_2), .DOPB(dopb_2));

  always_comb begin
    qa[0] = {dopa_0, doa_0};
    qa[1] = {dopa_1, doa_1};
    qa[2] = {dopa_2, doa_2};
    qb[0] = {dopb_0, dob_0};
    qb[1] = {dopb_1, dob_1};
    qb[2] = {dopb_2, dob_2};
  end

  task automatic chk(input string nm, input logic [17:0] got, input logic [17:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%05h expected=%05h at %0t", nm, got, exp, $time);
    end
  endtask

  // Word-level model of one clock edge, applied from the pre-edge inputs.
  task automatic model_edge();
    logic [17:0] old_a, old_b;
    old_a = m_mem[addra];
    old_b = m_mem[addrb];
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        e_a[i] = P_INIT_A;
        e_b[i] = P_INIT_B;
      end else begin
        if (ena) begin
          if (ssra)                 e_a[i] = P_SRVAL_A;
          else if (!wea)            e_a[i] = old_a;
          else if (mode_a[i] == WF) e_a[i] = {dipa, dia};
          else if (mode_a[i] == RF) e_a[i] = old_a;
        end
        if (enb) begin
          if (ssrb)                 e_b[i] = P_SRVAL_B;
          else if (!web)            e_b[i] = old_b;
          else if (mode_b[i] == WF) e_b[i] = {dipb, dib};
          else if (mode_b[i] == RF) e_b[i] = old_b;
        end
      end
    end
    if (enb && web) m_mem[addrb] = {dipb, dib};
    if (ena && wea) m_mem[addra] = {dipa, dia};
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_a(input logic en, input logic we, input logic ssr, input logic [9:0] ad, input logic [17:0] w);
    ena = en; wea = we; ssra = ssr; addra = ad; {dipa, dia} = w;
  endtask

  task automatic set_b(input logic en, input logic we, input logic ssr, input logic [9:0] ad, input logic [17:0] w);
    enb = en; web = we; ssrb = ssr; addrb = ad; {dipb, dib} = w;
  endtask

  // Every cycle: all six output registers against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("model_qa%0d", i), qa[i], e_a[i]);
        chk($sformatf("model_qb%0d", i), qb[i], e_b[i]);
      end
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) m_mem[i] = 18'h0;
    for (int i = 0; i < 3; i++) begin
      e_a[i] = P_INIT_A;
      e_b[i] = P_INIT_B;
    end
    rst_n = 1'b0;
    set_a(0, 0, 0, 10'd0, 18'h0);
    set_b(0, 0, 0, 10'd0, 18'h0);
    cmp_en = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("reset_qa", qa[i], 18'h3_1234);
      chk("reset_qb", qb[i], 18'h0_0ABC);
    end
    rst_n = 1'b1;
    tick();

    // preload through port B
    set_b(1, 1, 0, 10'd5,  18'h0_BEEF); tick();
    set_b(1, 1, 0, 10'd10, 18'h1_A5A5); tick();
    set_b(1, 1, 0, 10'd3,  18'h0_1111); tick();
    set_b(1, 1, 0, 10'd0,  18'h2_0C0C); tick();
    chk("b_wf_out", qb[0], 18'h2_0C0C);
    chk("b_nc_hold", qb[2], 18'h0_0ABC);
    chk("a_idle_hold", qa[0], 18'h3_1234);
    set_b(0, 0, 0, 10'd0, 18'h0);

    // basic read, 1-cycle latency
    set_a(1, 0, 0, 10'd10, 18'h0); tick();
    for (int i = 0; i < 3; i++) chk("read10", qa[i], 18'h1_A5A5);

    // write modes on addr 3
    set_a(1, 1, 0, 10'd3, 18'h0_2222); tick();
    chk("wm_read_first", qa[0], 18'h0_1111);
    chk("wm_write_first", qa[1], 18'h0_2222);
    chk("wm_no_change", qa[2], 18'h1_A5A5);
    set_a(1, 0, 0, 10'd3, 18'h0); tick();
    for (int i = 0; i < 3; i++) chk("read3_after", qa[i], 18'h0_2222);

    // disabled port holds while address moves
    for (int k = 0; k < 3; k++) begin
      set_a(0, 1, 1, 10'(k * 100 + 5), 18'h3_FFFF); tick();
    end
    for (int i = 0; i < 3; i++) chk("ena0_hold", qa[i], 18'h0_2222);

    // SSR with a simultaneous write
    set_a(1, 1, 1, 10'd20, 18'h0_7777); tick();
    for (int i = 0; i < 3; i++) chk("ssr_out", qa[i], 18'h0_00FF);
    set_a(1, 0, 0, 10'd20, 18'h0); tick();
    for (int i = 0; i < 3; i++) chk("ssr_wrote", qa[i], 18'h0_7777);

    // both ports write 1023: A wins
    set_a(1, 1, 0, 10'd1023, 18'h0_AAAA);
    set_b(1, 1, 0, 10'd1023, 18'h0_5555); tick();
    chk("coll_b_wf", qb[0], 18'h0_5555);
    set_b(0, 0, 0, 10'd0, 18'h0);
    set_a(1, 0, 0, 10'd1023, 18'h0); tick();
    for (int i = 0; i < 3; i++) chk("coll_a_wins", qa[i], 18'h0_AAAA);

    // A writes 0 while B reads 0: B sees old word; 0 and 1023 distinct
    set_a(1, 1, 0, 10'd0, 18'h0_1357);
    set_b(1, 0, 0, 10'd0, 18'h0); tick();
    for (int i = 0; i < 3; i++) chk("coll_b_old", qb[i], 18'h2_0C0C);
    set_a(0, 0, 0, 10'd0, 18'h0); tick();
    for (int i = 0; i < 3; i++) chk("b_read0_new", qb[i], 18'h0_1357);
    set_b(1, 0, 0, 10'd1023, 18'h0); tick();
    chk("addr1023_distinct", qb[0], 18'h0_AAAA);

    // asynchronous reset mid-stream; memory survives, writes during reset still land
    set_b(1, 1, 0, 10'd7, 18'h1_0707);
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      e_a[i] = P_INIT_A;
      e_b[i] = P_INIT_B;
    end
    #1;
    for (int i = 0; i < 3; i++) chk("async_rst_qa", qa[i], 18'h3_1234);
    chk("async_rst_qb", qb[1], 18'h0_0ABC);
    tick();
    chk("rst_hold_qa", qa[0], 18'h3_1234);
    rst_n = 1'b1;
    set_b(0, 0, 0, 10'd0, 18'h0);
    set_a(1, 0, 0, 10'd5, 18'h0); tick();
    for (int i = 0; i < 3; i++) chk("beef_kept", qa[i], 18'h0_BEEF);
    set_a(1, 0, 0, 10'd7, 18'h0); tick();
    chk("write_in_reset", qa[0], 18'h1_0707);

    // scanline: fill 0..639, read-and-erase sweep, then a verify sweep
    set_a(0, 0, 0, 10'd0, 18'h0);
    for (int i = 0; i < 640; i++) begin
      set_b(1, 1, 0, 10'(i), {i[1:0], 16'(i * 7 + 3)}); tick();
    end
    set_b(0, 0, 0, 10'd0, 18'h0);
    for (int i = 0; i < 640; i++) begin
      set_a(1, 1, 0, 10'(i), 18'h0); tick();
    end
    chk("erase_last_prior", qa[0], 18'h3_117C);
    for (int i = 0; i < 640; i++) begin
      set_a(1, 0, 0, 10'(i), 18'h0); tick();
    end
    for (int i = 0; i < 3; i++) chk("erase_zero", qa[i], 18'h0);

    set_a(0, 0, 0, 10'd0, 18'h0);
    tick();
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
